// File: rtl/cr_kme_fifo_param.sv
// Parametrised first-word-fall-through FIFO for KME pipeline stages: valid/stall write side,
// valid/ack read side, early-stall threshold, synchronous flush, occupancy and error tracking.
module cr_kme_fifo_param #(
  parameter int DATA_W       = 128,
  parameter int DEPTH        = 4,
  parameter int STALL_THRESH = 0,
  parameter int CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] fifo_in,
  input  logic              fifo_in_valid,
  input  logic              fifo_in_stall_override,
  output logic              fifo_in_stall,
  output logic [DATA_W-1:0] fifo_out,
  output logic              fifo_out_valid,
  input  logic              fifo_out_ack,
  input  logic              clear,
  input  logic              clear_err,
  output logic [CNT_W-1:0]  used_slots,
  output logic [CNT_W-1:0]  free_slots,
  output logic              fifo_overflow,
  output logic              fifo_underflow,
  output logic              overflow_sticky,
  output logic              underflow_sticky,
  output logic [CNT_W-1:0]  high_water
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  wptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [CNT_W-1:0]  hw_q;
  logic              full;
  logic              empty;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_evt;
  logic              unf_evt;
  logic              ovf_q;
  logic              unf_q;
  logic              ovf_sticky_q;
  logic              unf_sticky_q;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    full    = (count == DEPTH_C);
    empty   = (count == '0);
    wr_acc  = fifo_in_valid & ~full & ~clear;
    rd_acc  = fifo_out_ack & ~empty & ~clear;
    ovf_evt = fifo_in_valid & full & ~clear;
    unf_evt = fifo_out_ack & empty & ~clear;
  end

  // A simultaneous pop never makes room for a write into a full FIFO.
  always_comb begin
    count_nxt = count;
    if (clear)
      count_nxt = '0;
    else if (wr_acc && !rd_acc)
      count_nxt = count + CNT_W'(1);
    else if (rd_acc && !wr_acc)
      count_nxt = count - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      count <= count_nxt;
      if (clear) begin
        rptr <= '0;
        wptr <= '0;
      end else begin
        if (wr_acc) wptr <= ptr_inc(wptr);
        if (rd_acc) rptr <= ptr_inc(rptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= fifo_in;
  end

  // Sticky flags also see the visible pulse, so clear_err never wins against a live error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      ovf_sticky_q <= 1'b0;
      unf_sticky_q <= 1'b0;
      hw_q         <= '0;
    end else begin
      ovf_q        <= ovf_evt;
      unf_q        <= unf_evt;
      ovf_sticky_q <= ovf_evt | ovf_q | (ovf_sticky_q & ~clear_err);
      unf_sticky_q <= unf_evt | unf_q | (unf_sticky_q & ~clear_err);
      if (clear_err)
        hw_q <= count;
      else if (count_nxt > hw_q)
        hw_q <= count_nxt;
    end
  end

  assign used_slots       = count;
  assign free_slots       = DEPTH_C - count;
  assign fifo_out_valid   = ~empty;
  assign fifo_out         = empty ? '0 : mem[rptr];
  assign fifo_in_stall    = (free_slots <= THRESH_C) & ~fifo_in_stall_override;
  assign fifo_overflow    = ovf_q;
  assign fifo_underflow   = unf_q;
  assign overflow_sticky  = ovf_sticky_q;
  assign underflow_sticky = unf_sticky_q;
  assign high_water       = hw_q;

endmodule

// File: tb/tb_cr_kme_fifo_param.sv
// Bench for cr_kme_fifo_param: three configurations share one stimulus stream and are each
// checked against a queue-based reference model, plus directed vectors and corner sequences.
module tb_cr_kme_fifo_param;

  typedef logic [127:0] word_t;

  typedef struct {
    logic  inValid;
    word_t inData;
    logic  inAck;
    logic  expValid;
    word_t expOut;
    int    expUsed;
    int    expFree;
    logic  expStall;
    logic  expOvf;
    logic  expOvs;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  word_t din = '0;
  logic  inValid = 1'b0;
  logic  ack = 1'b0;
  logic  ovr = 1'b0;
  logic  clr = 1'b0;
  logic  clrErr = 1'b0;

  word_t       outA [3];
  logic        validA [3];
  logic        stallA [3];
  logic        ovfA [3];
  logic        unfA [3];
  logic        ovsA [3];
  logic        unsA [3];
  logic [31:0] usedA [3];
  logic [31:0] freeA [3];
  logic [31:0] hwA [3];

  logic [2:0] used0, free0, hw0, used1, free1, hw1;
  logic [1:0] used2, free2, hw2;

  int nCompared = 0;
  int nMismatched = 0;

  int dep [3];
  int th  [3];

  word_t mq [3][$];
  int    mhw [3];
  bit    movf [3];
  bit    munf [3];
  bit    movs [3];
  bit    muns [3];

  always #5 clk = ~clk;

  cr_kme_fifo_param #(.DATA_W(128), .DEPTH(4), .STALL_THRESH(0)) dut0 (
    .clk(clk), .rst(rst), .fifo_in(din), .fifo_in_valid(inValid),
    .fifo_in_stall_override(ovr), .fifo_in_stall(stallA[0]), .fifo_out(outA[0]),
    .fifo_out_valid(validA[0]), .fifo_out_ack(ack), .clear(clr), .clear_err(clrErr),
    .used_slots(used0), .free_slots(free0), .fifo_overflow(ovfA[0]),
    .fifo_underflow(unfA[0]), .overflow_sticky(ovsA[0]), .underflow_sticky(unsA[0]),
    .high_water(hw0));

  cr_kme_fifo_param #(.DATA_W(128), .DEPTH(4), .STALL_THRESH(1)) dut1 (
    .clk(clk), .rst(rst), .fifo_in(din), .fifo_in_valid(inValid),
    .fifo_in_stall_override(ovr), .fifo_in_stall(stallA[1]), .fifo_out(outA[1]),
    .fifo_out_valid(validA[1]), .fifo_out_ack(ack), .clear(clr), .clear_err(clrErr),
    .used_slots(used1), .free_slots(free1), .fifo_overflow(ovfA[1]),
    .fifo_underflow(unfA[1]), .overflow_sticky(ovsA[1]), .underflow_sticky(unsA[1]),
    .high_water(hw1));

  cr_kme_fifo_param #(.DATA_W(128), .DEPTH(3), .STALL_THRESH(0)) dut2 (
    .clk(clk), .rst(rst), .fifo_in(din), .fifo_in_valid(inValid),
    .fifo_in_stall_override(ovr), .fifo_in_stall(stallA[2]), .fifo_out(outA[2]),
    .fifo_out_valid(validA[2]), .fifo_out_ack(ack), .clear(clr), .clear_err(clrErr),
    .used_slots(used2), .free_slots(free2), .fifo_overflow(ovfA[2]),
    .fifo_underflow(unfA[2]), .overflow_sticky(ovsA[2]), .underflow_sticky(unsA[2]),
    .high_water(hw2));

  assign usedA[0] = 32'(used0);
  assign freeA[0] = 32'(free0);
  assign hwA[0]   = 32'(hw0);
  assign usedA[1] = 32'(used1);
  assign freeA[1] = 32'(free1);
  assign hwA[1]   = 32'(hw1);
  assign usedA[2] = 32'(used2);
  assign freeA[2] = 32'(free2);
  assign hwA[2]   = 32'(hw2);

  task automatic checkOutput(input string name, input word_t act, input word_t exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input word_t d, input logic a,
                               input logic o, input logic c, input logic ce);
    inValid = v;
    din     = d;
    ack     = a;
    ovr     = o;
    clr     = c;
    clrErr  = ce;
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      mhw[k]  = 0;
      movf[k] = 0;
      munf[k] = 0;
      movs[k] = 0;
      muns[k] = 0;
    end
  endtask

  // Reference behaviour: a queue per configuration, updated once per accepted clock edge.
  task automatic modelStep();
    for (int k = 0; k < 3; k++) begin
      int sz = mq[k].size();
      bit isFull = (sz == dep[k]);
      bit isEmpty = (sz == 0);
      bit oe = 0;
      bit ue = 0;
      if (clr) begin
        mq[k].delete();
      end else begin
        oe = inValid && isFull;
        ue = ack && isEmpty;
        if (ack && !isEmpty) void'(mq[k].pop_front());
        if (inValid && !isFull) mq[k].push_back(din);
      end
      movs[k] = oe | movf[k] | (movs[k] & !clrErr);
      muns[k] = ue | munf[k] | (muns[k] & !clrErr);
      movf[k] = oe;
      munf[k] = ue;
      if (clrErr) mhw[k] = sz;
      else if (mq[k].size() > mhw[k]) mhw[k] = mq[k].size();
    end
  endtask

  task automatic checkAll();
    for (int k = 0; k < 3; k++) begin
      int sz = mq[k].size();
      word_t expOut = (sz != 0) ? mq[k][0] : '0;
      logic expStall = ((dep[k] - sz) <= th[k]) && !ovr;
      checkOutput($sformatf("dut%0d valid", k), validA[k], sz != 0);
      checkOutput($sformatf("dut%0d out", k), outA[k], expOut);
      checkOutput($sformatf("dut%0d used", k), usedA[k], sz);
      checkOutput($sformatf("dut%0d free", k), freeA[k], dep[k] - sz);
      checkOutput($sformatf("dut%0d stall", k), stallA[k], expStall);
      checkOutput($sformatf("dut%0d overflow", k), ovfA[k], movf[k]);
      checkOutput($sformatf("dut%0d underflow", k), unfA[k], munf[k]);
      checkOutput($sformatf("dut%0d ovf_sticky", k), ovsA[k], movs[k]);
      checkOutput($sformatf("dut%0d unf_sticky", k), unsA[k], muns[k]);
      checkOutput($sformatf("dut%0d high_water", k), hwA[k], mhw[k]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, '0, 0, 0, 0, 0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    checkAll();
    rst = 1'b0;
  endtask

  vec_t tbl [10];

  initial begin
    dep[0] = 4; th[0] = 0;
    dep[1] = 4; th[1] = 1;
    dep[2] = 3; th[2] = 0;

    tbl[0] = '{1, 128'hA0, 0, 1, 128'hA0, 1, 3, 0, 0, 0};
    tbl[1] = '{1, 128'hA1, 0, 1, 128'hA0, 2, 2, 0, 0, 0};
    tbl[2] = '{1, 128'hA2, 0, 1, 128'hA0, 3, 1, 0, 0, 0};
    tbl[3] = '{1, 128'hA3, 0, 1, 128'hA0, 4, 0, 1, 0, 0};
    tbl[4] = '{1, 128'hA4, 0, 1, 128'hA0, 4, 0, 1, 1, 1};
    tbl[5] = '{0, 128'h00, 0, 1, 128'hA0, 4, 0, 1, 0, 1};
    tbl[6] = '{0, 128'h00, 1, 1, 128'hA1, 3, 1, 0, 0, 1};
    tbl[7] = '{0, 128'h00, 1, 1, 128'hA2, 2, 2, 0, 0, 1};
    tbl[8] = '{0, 128'h00, 1, 1, 128'hA3, 1, 3, 0, 0, 1};
    tbl[9] = '{0, 128'h00, 1, 0, 128'h00, 0, 4, 0, 0, 1};

    doReset();

    // Fill to full, overflow once, then drain in order (DEPTH=4, threshold 0).
    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].inValid, tbl[i].inData, tbl[i].inAck, 0, 0, 0);
      cycle();
      checkOutput($sformatf("t1[%0d] valid", i), validA[0], tbl[i].expValid);
      checkOutput($sformatf("t1[%0d] out", i), outA[0], tbl[i].expOut);
      checkOutput($sformatf("t1[%0d] used", i), usedA[0], tbl[i].expUsed);
      checkOutput($sformatf("t1[%0d] free", i), freeA[0], tbl[i].expFree);
      checkOutput($sformatf("t1[%0d] stall", i), stallA[0], tbl[i].expStall);
      checkOutput($sformatf("t1[%0d] overflow", i), ovfA[0], tbl[i].expOvf);
      checkOutput($sformatf("t1[%0d] ovf_sticky", i), ovsA[0], tbl[i].expOvs);
    end

    // Streaming through a DEPTH=3 FIFO across pointer wrap.
    doReset();
    applyStimulus(1, 128'd0, 0, 0, 0, 0);
    cycle();
    checkOutput("t2 first out", outA[2], 0);
    checkOutput("t2 first valid", validA[2], 1);
    for (int k = 1; k < 10; k++) begin
      applyStimulus(1, word_t'(k), 1, 0, 0, 0);
      cycle();
      checkOutput($sformatf("t2 out %0d", k), outA[2], word_t'(k));
      checkOutput($sformatf("t2 used %0d", k), usedA[2], 1);
    end
    checkOutput("t2 high_water", hwA[2], 1);
    applyStimulus(0, '0, 1, 0, 0, 0);
    cycle();
    checkOutput("t2 drained", validA[2], 0);

    // Early stall at threshold 1 and the override (DEPTH=4, threshold 1).
    doReset();
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1, word_t'(k), 0, 0, 0, 0);
      cycle();
      if (k == 2) checkOutput("t3 stall at 2", stallA[1], 0);
    end
    checkOutput("t3 stall at 3", stallA[1], 1);
    checkOutput("t3 used at 3", usedA[1], 3);
    applyStimulus(0, '0, 0, 1, 0, 0);
    #1;
    checkOutput("t3 stall overridden", stallA[1], 0);
    applyStimulus(1, 128'd4, 0, 1, 0, 0);
    cycle();
    checkOutput("t3 4th accepted", usedA[1], 4);
    checkOutput("t3 4th no overflow", ovfA[1], 0);
    applyStimulus(1, 128'd5, 0, 1, 0, 0);
    cycle();
    checkOutput("t3 5th overflow", ovfA[1], 1);
    checkOutput("t3 5th used", usedA[1], 4);
    checkOutput("t3 stall still overridden", stallA[1], 0);
    applyStimulus(0, '0, 0, 0, 0, 0);
    #1;
    checkOutput("t3 stall released", stallA[1], 1);

    // Underflow pulse and sticky flag interaction with clear_err.
    doReset();
    applyStimulus(0, '0, 1, 0, 0, 0);
    cycle();
    checkOutput("t4 underflow pulse", unfA[0], 1);
    checkOutput("t4 out zero", outA[0], 0);
    checkOutput("t4 sticky set", unsA[0], 1);
    applyStimulus(0, '0, 1, 0, 0, 1);
    cycle();
    checkOutput("t4 sticky kept", unsA[0], 1);
    applyStimulus(0, '0, 0, 0, 0, 0);
    cycle();
    checkOutput("t4 pulse gone", unfA[0], 0);
    applyStimulus(0, '0, 0, 0, 0, 1);
    cycle();
    checkOutput("t4 sticky cleared", unsA[0], 0);

    // Flush wins over a same-cycle write and read; high_water survives until clear_err.
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, word_t'(8'h30 + k), 0, 0, 0, 0);
      cycle();
    end
    applyStimulus(1, 128'h99, 1, 0, 1, 0);
    cycle();
    checkOutput("t5 used", usedA[0], 0);
    checkOutput("t5 valid", validA[0], 0);
    checkOutput("t5 no overflow", ovfA[0], 0);
    checkOutput("t5 no underflow", unfA[0], 0);
    checkOutput("t5 hw kept", hwA[0], 3);
    applyStimulus(0, '0, 0, 0, 0, 1);
    cycle();
    checkOutput("t5 hw reloaded", hwA[0], 0);

    // Asynchronous reset between clock edges.
    applyStimulus(1, 128'h11, 0, 0, 0, 0);
    cycle();
    applyStimulus(1, 128'h22, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checkAll();
    checkOutput("t6 async valid", validA[0], 0);
    checkOutput("t6 async free", freeA[0], 4);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 128'h55, 0, 0, 0, 0);
    cycle();
    checkOutput("t6 fresh write", outA[0], 128'h55);

    // Randomised traffic against the reference model.
    doReset();
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 99) < 60,
                    {$urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 99) < 50,
                    $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 4,
                    $urandom_range(0, 99) < 5);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cr_kme_fifo_param.md
Name: cr_kme_fifo_param

Overview:
Parametrised successor to the KME fixed 128-bit x 2-entry FIFO wrapper. It is a first-word-fall-through FIFO with a valid/ack read side and a valid/stall write side. Over the fixed block it adds:
- programmable width and depth;
- a programmable early-stall threshold;
- a working stall override;
- synchronous flush;
- occupancy outputs;
- sticky error flags and a high-watermark.

It sits between KME pipeline stages such as key-fetch to AES-core and decoupled request queues.

Parameters:
DATA_W, 128, data width in bits (>=1)
DEPTH, 4, number of entries (>=2; need not be a power of 2)
STALL_THRESH, 0, fifo_in_stall asserts when free_slots <= STALL_THRESH (0 <= STALL_THRESH < DEPTH)
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  input  1  clock; all logic rising-edge
rst  input  1  reset, asynchronous assert, active-high; one clock, asynchronous active-high reset
fifo_in  input  DATA_W  write data
fifo_in_valid  input  1  write request
fifo_in_stall_override  input  1  forces fifo_in_stall low (does not force acceptance)
fifo_in_stall  output  1  backpressure to producer
fifo_out  output  DATA_W  head entry; all-zero when empty
fifo_out_valid  output  1  FIFO non-empty
fifo_out_ack  input  1  consumer pops head when fifo_out_valid=1
clear  input  1  synchronous flush
clear_err  input  1  clears sticky flags and watermark
used_slots  output  CNT_W  current occupancy
free_slots  output  CNT_W  DEPTH - used_slots
fifo_overflow  output  1  1-cycle pulse: write dropped because full
fifo_underflow  output  1  1-cycle pulse: ack while empty
overflow_sticky  output  1  latched overflow
underflow_sticky  output  1  latched underflow
high_water  output  CNT_W  max used_slots since reset/clear_err

Behaviour:
- Reset (rst=1, asynchronous):
  - read/write pointers, count, pulses, sticky flags and high_water all go to 0.
  - Outputs: fifo_out_valid=0, fifo_out=0, used_slots=0, free_slots=DEPTH, fifo_in_stall=0.
  - Storage array is not reset.
  - Reset mid-transfer discards all contents.
- Pointers:
  - Circular; each pointer increments mod DEPTH and wraps from DEPTH-1 to 0.
  - Full/empty are derived from count, not from pointer equality.
- Write accepted (wr_acc) = fifo_in_valid & (used_slots < DEPTH) & ~clear.
  - Full test uses the current cycle's count; a simultaneous pop does not make room.
  - Accepted data is written to wptr and is visible on fifo_out the next cycle if the FIFO was empty (1-cycle fall-through latency).
- Read accepted (rd_acc) = fifo_out_valid & fifo_out_ack & ~clear.
  - Head advances; the next entry appears the following cycle.
- fifo_overflow = fifo_in_valid & full & ~clear. Data is dropped and the count is unchanged.
- fifo_underflow = fifo_out_ack & ~fifo_out_valid & ~clear.
- Both pulses are registered: high for exactly the cycle after the offending event.
- Count update:
  - +1 on wr_acc only;
  - -1 on rd_acc only;
  - unchanged on both or neither.
  - Simultaneous read and write at DEPTH-1 or 1 entries keeps count.
- fifo_out_valid = (used_slots != 0). fifo_out = mem[rptr] when valid, else 0.
- fifo_in_stall = (free_slots <= STALL_THRESH) & ~fifo_in_stall_override. This is combinational from registered count plus the override.
  - With STALL_THRESH=0 it matches the legacy block: stall only when full.
  - With the override set while full, writes are still dropped and flagged as overflow.
- clear:
  - Pointers and count go to 0 next cycle.
  - Has priority over same-cycle write/read; no pulses are generated that cycle.
  - Sticky flags and high_water are unaffected.
- Sticky flags:
  - Set on the corresponding pulse.
  - Cleared by clear_err.
  - If a pulse and clear_err occur in the same cycle, the flag ends set.
- high_water:
  - Updated to the next-state count whenever it exceeds the current value.
  - clear_err loads the current used_slots.
- No combinational path from fifo_in_valid or fifo_out_ack to any output.

Test Plan:
1. DATA_W=128, DEPTH=4, STALL_THRESH=0: write 0xA0..0xA3 in back-to-back cycles, ack held 0.
   - fifo_in_stall=1 after the 4th write; used_slots=4, free_slots=0.
   - A 5th write gives fifo_overflow=1 for one cycle and overflow_sticky=1.
   - Popping yields 0xA0..0xA3 in order.
2. DEPTH=3 (non-power-of-2): stream 10 words with a simultaneous write and ack every cycle after the first write.
   - Output order 0..9 is preserved across pointer wrap; used_slots stays at 1; high_water=1.
3. DEPTH=4, STALL_THRESH=1: write 3 words.
   - fifo_in_stall=1 at used_slots=3.
   - Asserting fifo_in_stall_override drives stall to 0; the 4th write is accepted and the 5th overflows.
4. Empty FIFO with fifo_out_ack=1.
   - fifo_underflow pulses one cycle later; fifo_out=0; underflow_sticky=1.
   - clear_err with a simultaneous underflow leaves the flag set; clear_err alone clears it.
5. FIFO holding 3 entries: assert clear together with fifo_in_valid and ack.
   - Next cycle used_slots=0, fifo_out_valid=0, no pulses.
   - high_water is still 3 until clear_err, after which it reads 0.
6. Assert rst asynchronously mid-stream, between clock edges.
   - Outputs go to their reset values immediately.
   - After rst deasserts, a fresh write appears on fifo_out one cycle later.
